board_scanout_reader: RTL
=========================

Name: board_scanout_reader

Overview:
Read side of the 80x40 board pixel map. The map writer stamps landed shapes into the map. This block reads one map row per four screen lines into a double-buffered line buffer during horizontal blanking. During active video it returns the 4-bit palette index for the current DrawX/DrawY to the colour mapper. Map reads go through a single-outstanding request/valid port in front of the board storage.

Parameters:
BOARD_X0, 250, screen x of the board's left edge
BOARD_Y0, 100, screen y of the board's top edge
CELL_PX, 4, screen pixels per map cell in each axis (power of two)
MAP_COLS, 40, map cells per row (board is 160 px wide)
MAP_ROWS, 80, map rows (board is 320 px tall)
FETCH_X, 640, DrawX value that triggers a fetch (start of horizontal blanking)
V_LAST, 524, last DrawY of the frame

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  synchronous active-low reset
DrawX  in  10  current screen x
DrawY  in  10  current screen y
rd_req  out  1  one-cycle read request strobe
rd_row  out  7  map row being read
rd_col  out  6  map column being read
rd_valid  in  1  read data valid, asserted one or more cycles after rd_req
rd_data  in  4  cell value
pix_idx  out  4  palette index for the pixel presented on the previous cycle
in_board  out  1  previous-cycle pixel lies inside the board
fetch_busy  out  1  fetch FSM not IDLE
underrun  out  1  sticky: a fetch missed its swap deadline

Behaviour:
- Reset (Reset_n=0 at a Clk edge) sets all of the following to 0:
  - all outputs;
  - both line buffers;
  - the front-select bit, pending_swap and underrun;
  - FSM state, which goes to IDLE.
- Reset applied mid-fetch abandons the fetch. Any later rd_valid is ignored.
- Next line: ny = (DrawY==V_LAST) ? 0 : DrawY+1.
- Fetch trigger: the cycle with DrawX==FETCH_X, provided all of the following hold:
  - BOARD_Y0 <= ny < BOARD_Y0 + MAP_ROWS*CELL_PX;
  - (ny-BOARD_Y0) mod CELL_PX == 0;
  - FSM is IDLE.
  The fetched row is (ny-BOARD_Y0)/CELL_PX.
- A trigger while the FSM is not IDLE is dropped and sets underrun.
- FSM states:
  - IDLE: on trigger, latch the row, set col=0, go to REQ.
  - REQ: rd_req=1 for exactly one cycle, rd_row/rd_col driven. Go to WAIT.
  - WAIT: rd_row/rd_col held stable. On rd_valid, write rd_data into back[col]. If col==MAP_COLS-1, go to DONE; otherwise col++ and go to REQ.
  - DONE: set pending_swap=1, go to IDLE.
- Minimum cost is 2 cycles per cell, so 80 cycles per row with a 1-cycle-latency responder.
- rd_valid outside WAIT is ignored.
- Swap: on the cycle with DrawX==0:
  - pending_swap=1: toggle front-select and clear pending_swap.
  - FSM not IDLE: set underrun; front is not swapped and keeps the previous row; the fetch continues and swaps at the next DrawX==0.
- Output path is registered with 1-cycle latency:
  - in_board = (BOARD_X0 <= DrawX < BOARD_X0+MAP_COLS*CELL_PX) and (BOARD_Y0 <= DrawY < BOARD_Y0+MAP_ROWS*CELL_PX).
  - pix_idx = in_board ? front[(DrawX-BOARD_X0)/CELL_PX] : 0.
- Subtractions are done in 10-bit unsigned arithmetic. The range check is made before indexing, so there are no out-of-range reads.
- The line buffer is written only in WAIT and read only via front. Front and back never alias.
- underrun clears only on reset.

Optional Feature:
- Macro: BOARD_BORDER_EN.
- Defined: screen pixels forming a 1-pixel frame immediately outside the board rectangle output pix_idx=4'hF with in_board=0. The frame is x = BOARD_X0-1 or BOARD_X0+160, and y = BOARD_Y0-1 or BOARD_Y0+320, spanning the board extent plus its corners.
- Undefined: those pixels output 0, like every other off-board pixel.

Decomposition:
- Shared package board_pkg holds:
  - the typedef cell_t (logic [3:0]);
  - constants MAP_COLS, MAP_ROWS, CELL_PX, BOARD_X0, BOARD_Y0;
  - the fetch-state enum {IDLE, REQ, WAIT, DONE};
  - BORDER_IDX = 4'hF.
- One natural sub-module: board_line_buffer, a two-bank 40x4 store with a write port (bank, col, data, we) and a combinational read port (bank, col).

Test Plan:
1. Reset: hold Reset_n=0 for 3 cycles with random DrawX/DrawY and rd_valid -> all outputs 0; first post-reset pix_idx=0.
2. Row-0 fetch: DrawY=99, DrawX=640; responder with 1-cycle latency returns rd_data=col[3:0] -> exactly 40 rd_req pulses with rd_row=0, rd_col=0..39 in order; then on DrawY=100, DrawX=250+4k -> pix_idx=k mod 16 and in_board=1 one cycle later, for k=0..39.
3. No refetch inside a cell row: DrawY=100 and DrawY=101 at DrawX=640 -> no rd_req. DrawY=103 -> fetch rd_row=1. DrawY=419 -> no fetch; ny=420 is off-board.
4. Off-board and edges: DrawY=150 with DrawX=249, 410, 639 -> pix_idx=0, in_board=0. DrawX=250 and 409 -> in_board=1 with col 0 and col 39 data.
5. Underrun: responder latency 10 cycles -> swap at DrawX=0 finds FSM in WAIT; underrun=1 and stays 1; the line shows the previous row; the new row appears on the following line.
6. Reset mid-fetch: assert Reset_n=0 while in WAIT at col 17, then assert rd_valid after release -> rd_req=0, fetch_busy=0, back buffer unchanged (all 0), no swap occurs.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and geometry for the board scanout read path.
package board_pkg;

  typedef logic [3:0] cell_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} fetch_state_t;

  localparam int MAP_COLS   = 40;
  localparam int MAP_ROWS   = 80;
  localparam int CELL_PX    = 4;
  localparam int CELL_SHIFT = $clog2(CELL_PX);

  localparam logic [9:0] BOARD_X0  = 10'd250;
  localparam logic [9:0] BOARD_Y0  = 10'd100;
  localparam logic [9:0] BOARD_X1  = BOARD_X0 + 10'(MAP_COLS * CELL_PX);
  localparam logic [9:0] BOARD_Y1  = BOARD_Y0 + 10'(MAP_ROWS * CELL_PX);
  localparam logic [9:0] FETCH_X   = 10'd640;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [9:0] CELL_MASK = 10'(CELL_PX - 1);
  localparam logic [5:0] COL_LAST  = 6'(MAP_COLS - 1);

  localparam cell_t BORDER_IDX = 4'hF;

  function automatic logic [9:0] next_line(input logic [9:0] y);
    return (y == V_LAST) ? 10'd0 : y + 10'd1;
  endfunction

endpackage

// File: rtl/board_line_buffer.sv
// Two-bank line store: one bank is filled by the fetcher while the other is scanned out.
module board_line_buffer
  import board_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic       wbank,
  input  logic [5:0] wcol,
  input  cell_t      wdata,
  input  logic       rbank,
  input  logic [5:0] rcol,
  output cell_t      rdata
);

  cell_t mem [2][MAP_COLS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < MAP_COLS; c++)
          mem[b][c] <= '0;
    end else if (we) begin
      mem[wbank][wcol] <= wdata;
    end
  end

  assign rdata = mem[rbank][rcol];

endmodule

// File: rtl/board_scanout_reader.sv
// Board map scanout: fetches one map row per cell row in hblank, serves palette indices in active video.
// Optional BOARD_BORDER_EN draws a 1-pixel frame (index BORDER_IDX) just outside the board.
module board_scanout_reader
  import board_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       rd_req,
  output logic [6:0] rd_row,
  output logic [5:0] rd_col,
  input  logic       rd_valid,
  input  logic [3:0] rd_data,
  output logic [3:0] pix_idx,
  output logic       in_board,
  output logic       fetch_busy,
  output logic       underrun
);

  fetch_state_t state;
  logic         front_sel;
  logic         pending_swap;

  logic [9:0] ny, ny_off;
  logic       trig_hit, swap_now;
  logic [6:0] trig_row;

  assign ny       = next_line(DrawY);
  assign ny_off   = ny - BOARD_Y0;
  assign trig_hit = (DrawX == FETCH_X) && (ny >= BOARD_Y0) && (ny < BOARD_Y1) &&
                    ((ny_off & CELL_MASK) == '0);
  assign trig_row = 7'(ny_off >> CELL_SHIFT);
  assign swap_now = (DrawX == '0);

  assign fetch_busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state        <= IDLE;
      rd_req       <= 1'b0;
      rd_row       <= '0;
      rd_col       <= '0;
      front_sel    <= 1'b0;
      pending_swap <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      rd_req <= 1'b0;
      case (state)
        IDLE: if (trig_hit) begin
          rd_row <= trig_row;
          rd_col <= '0;
          rd_req <= 1'b1;
          state  <= REQ;
        end
        REQ:  state <= WAIT;
        WAIT: if (rd_valid) begin
          if (rd_col == COL_LAST) begin
            state <= DONE;
          end else begin
            rd_col <= rd_col + 6'd1;
            rd_req <= 1'b1;
            state  <= REQ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A fetch still running at the swap point leaves the old row on screen.
      if (swap_now && pending_swap) front_sel <= ~front_sel;
      if (state == DONE)  pending_swap <= 1'b1;
      else if (swap_now)  pending_swap <= 1'b0;
      if ((trig_hit || swap_now) && state != IDLE) underrun <= 1'b1;
    end
  end

  logic       x_in, y_in, board_hit, border_hit;
  logic [5:0] rcol;
  cell_t      front_data;

  assign x_in      = (DrawX >= BOARD_X0) && (DrawX < BOARD_X1);
  assign y_in      = (DrawY >= BOARD_Y0) && (DrawY < BOARD_Y1);
  assign board_hit = x_in && y_in;
  assign rcol      = board_hit ? 6'((DrawX - BOARD_X0) >> CELL_SHIFT) : '0;

`ifdef BOARD_BORDER_EN
  assign border_hit =
    ((DrawX == BOARD_X0 - 10'd1 || DrawX == BOARD_X1) &&
     (DrawY >= BOARD_Y0 - 10'd1) && (DrawY <= BOARD_Y1)) ||
    ((DrawY == BOARD_Y0 - 10'd1 || DrawY == BOARD_Y1) &&
     (DrawX >= BOARD_X0 - 10'd1) && (DrawX <= BOARD_X1));
`else
  assign border_hit = 1'b0;
`endif

  board_line_buffer u_lbuf (
    .clk   (Clk),
    .rst_n (Reset_n),
    .we    ((state == WAIT) && rd_valid),
    .wbank (~front_sel),
    .wcol  (rd_col),
    .wdata (rd_data),
    .rbank (front_sel),
    .rcol  (rcol),
    .rdata (front_data)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      in_board <= 1'b0;
      pix_idx  <= '0;
    end else begin
      in_board <= board_hit;
      pix_idx  <= board_hit ? front_data : (border_hit ? BORDER_IDX : 4'h0);
    end
  end

endmodule
